// File: rtl/rob_pkg.sv
// Shared sizing constants, entry type and pointer helper for the reorder buffer.
package rob_pkg;

    localparam int DEPTH   = 64;
    localparam int PR_W    = 8;
    localparam int XLEN    = 64;
    localparam int FLAGS_W = 13;
    localparam int ARF_W   = 5;

    localparam int AW    = $clog2(DEPTH);
    localparam int CNT_W = AW + 1;

    typedef struct packed {
        logic               valid;
        logic               done;
        logic [ARF_W-1:0]   arf;
        logic [XLEN-1:0]    pc;
        logic [XLEN-1:0]    result;
        logic [FLAGS_W-1:0] flags;
    } rob_entry_t;

    // DEPTH is a power of two, so the natural AW-bit overflow is the wrap.
    function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
        return p + AW'(1);
    endfunction

endpackage

// File: rtl/rob_storage.sv
// Payload arrays of the reorder buffer: alloc port writes arf/pc, writeback port
// writes result/flags, and one combinational read port serves the head entry.
module rob_storage
    import rob_pkg::*;
(
    input  logic               i_clock,
    input  logic               i_alloc_en,
    input  logic [AW-1:0]      i_alloc_idx,
    input  logic [ARF_W-1:0]   i_alloc_arf,
    input  logic [XLEN-1:0]    i_alloc_pc,
    input  logic               i_wb_en,
    input  logic [AW-1:0]      i_wb_idx,
    input  logic [XLEN-1:0]    i_wb_result,
    input  logic [FLAGS_W-1:0] i_wb_flags,
    input  logic [AW-1:0]      i_rd_idx,
    output logic [ARF_W-1:0]   o_rd_arf,
    output logic [XLEN-1:0]    o_rd_pc,
    output logic [XLEN-1:0]    o_rd_result,
    output logic [FLAGS_W-1:0] o_rd_flags
);

    // Payload is never reset; the valid/done bits in the top level gate every use.
    logic [ARF_W-1:0]   r_arf    [DEPTH];
    logic [XLEN-1:0]    r_pc     [DEPTH];
    logic [XLEN-1:0]    r_result [DEPTH];
    logic [FLAGS_W-1:0] r_flags  [DEPTH];

    always_ff @(posedge i_clock) begin
        if (i_alloc_en) begin
            r_arf[i_alloc_idx] <= i_alloc_arf;
            r_pc[i_alloc_idx]  <= i_alloc_pc;
        end
    end

    always_ff @(posedge i_clock) begin
        if (i_wb_en) begin
            r_result[i_wb_idx] <= i_wb_result;
            r_flags[i_wb_idx]  <= i_wb_flags;
        end
    end

    assign o_rd_arf    = r_arf[i_rd_idx];
    assign o_rd_pc     = r_pc[i_rd_idx];
    assign o_rd_result = r_result[i_rd_idx];
    assign o_rd_flags  = r_flags[i_rd_idx];

endmodule

// File: rtl/reorder_buffer.sv
// In-order reorder buffer: allocates entries at the tail for rename, marks them done on
// writeback and retires completed entries from the head, one per cycle.
module reorder_buffer
    import rob_pkg::*;
(
    input  logic               clock,
    input  logic               reset_n,
    output logic [PR_W-1:0]    next_free,
    output logic               is_free,
    input  logic [ARF_W-1:0]   alloc_arf,
    input  logic [XLEN-1:0]    alloc_pc,
    input  logic               do_alloc,
    input  logic               wb_valid,
    input  logic [PR_W-1:0]    wb_pr,
    input  logic [XLEN-1:0]    wb_result,
    input  logic [FLAGS_W-1:0] wb_flags,
    input  logic               flush,
    output logic [ARF_W-1:0]   commit_arf,
    output logic [XLEN-1:0]    commit_result,
    output logic [XLEN-1:0]    commit_pc,
    output logic [FLAGS_W-1:0] commit_flags,
    output logic               commit_valid
);

    logic [DEPTH-1:0] r_valid;
    logic [DEPTH-1:0] r_done;
    logic [AW-1:0]    r_head;
    logic [AW-1:0]    r_tail;
    logic [CNT_W-1:0] r_count;

    logic               w_alloc;
    logic               w_wb;
    logic               w_wb_in_range;
    logic [AW-1:0]      w_wb_idx;
    logic               w_commit;
    rob_entry_t         w_head_entry;
    logic [ARF_W-1:0]   w_rd_arf;
    logic [XLEN-1:0]    w_rd_pc;
    logic [XLEN-1:0]    w_rd_result;
    logic [FLAGS_W-1:0] w_rd_flags;

    // Alloc handshake: is_free is the ready, do_alloc the valid; an entry is taken at the
    // edge where both are high, and is_free reflects only the pre-edge count.
    assign next_free = PR_W'(r_tail);
    assign is_free   = (r_count < CNT_W'(DEPTH));
    assign w_alloc   = do_alloc && is_free;

    assign w_wb_in_range = ({1'b0, wb_pr} < (PR_W + 1)'(DEPTH));
    assign w_wb_idx      = wb_pr[AW-1:0];
    assign w_wb          = wb_valid && w_wb_in_range && r_valid[w_wb_idx];

    rob_storage u_storage (
        .i_clock     (clock),
        .i_alloc_en  (w_alloc && !flush),
        .i_alloc_idx (r_tail),
        .i_alloc_arf (alloc_arf),
        .i_alloc_pc  (alloc_pc),
        .i_wb_en     (w_wb && !flush),
        .i_wb_idx    (w_wb_idx),
        .i_wb_result (wb_result),
        .i_wb_flags  (wb_flags),
        .i_rd_idx    (r_head),
        .o_rd_arf    (w_rd_arf),
        .o_rd_pc     (w_rd_pc),
        .o_rd_result (w_rd_result),
        .o_rd_flags  (w_rd_flags)
    );

    always_comb begin
        w_head_entry        = '0;
        w_head_entry.valid  = r_valid[r_head];
        w_head_entry.done   = r_done[r_head];
        w_head_entry.arf    = w_rd_arf;
        w_head_entry.pc     = w_rd_pc;
        w_head_entry.result = w_rd_result;
        w_head_entry.flags  = w_rd_flags;
    end

    assign w_commit = w_head_entry.valid && w_head_entry.done;

    // The tail slot is never valid unless the buffer is full (and then alloc is refused),
    // so alloc, writeback and commit never collide on one entry's valid/done bits.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_valid <= '0;
            r_done  <= '0;
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else if (flush) begin
            r_valid <= '0;
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (w_wb) begin
                r_done[w_wb_idx] <= 1'b1;
            end
            if (w_commit) begin
                r_valid[r_head] <= 1'b0;
                r_head          <= ptr_inc(r_head);
            end
            if (w_alloc) begin
                r_valid[r_tail] <= 1'b1;
                r_done[r_tail]  <= 1'b0;
                r_tail          <= ptr_inc(r_tail);
            end
            case ({w_alloc, w_commit})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Commit fields hold their last retired values until the next retirement or reset.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            commit_valid  <= 1'b0;
            commit_arf    <= '0;
            commit_pc     <= '0;
            commit_result <= '0;
            commit_flags  <= '0;
        end else if (flush) begin
            commit_valid <= 1'b0;
        end else begin
            commit_valid <= w_commit;
            if (w_commit) begin
                commit_arf    <= w_head_entry.arf;
                commit_pc     <= w_head_entry.pc;
                commit_result <= w_head_entry.result;
                commit_flags  <= w_head_entry.flags;
            end
        end
    end

endmodule

// File: tb/tb_reorder_buffer.sv
// Bench for reorder_buffer: a program-order queue model checked against every output on
// each falling clock edge, directed scenarios with literal expectations, and random traffic.
module tb_reorder_buffer;
    import rob_pkg::*;

    logic               clock = 1'b0;
    logic               reset_n = 1'b1;
    logic [PR_W-1:0]    next_free;
    logic               is_free;
    logic [ARF_W-1:0]   alloc_arf = '0;
    logic [XLEN-1:0]    alloc_pc = '0;
    logic               do_alloc = 1'b0;
    logic               wb_valid = 1'b0;
    logic [PR_W-1:0]    wb_pr = '0;
    logic [XLEN-1:0]    wb_result = '0;
    logic [FLAGS_W-1:0] wb_flags = '0;
    logic               flush = 1'b0;
    logic [ARF_W-1:0]   commit_arf;
    logic [XLEN-1:0]    commit_result;
    logic [XLEN-1:0]    commit_pc;
    logic [FLAGS_W-1:0] commit_flags;
    logic               commit_valid;

    int n_checks = 0;
    int n_fail   = 0;

    reorder_buffer dut (
        .clock         (clock),
        .reset_n       (reset_n),
        .next_free     (next_free),
        .is_free       (is_free),
        .alloc_arf     (alloc_arf),
        .alloc_pc      (alloc_pc),
        .do_alloc      (do_alloc),
        .wb_valid      (wb_valid),
        .wb_pr         (wb_pr),
        .wb_result     (wb_result),
        .wb_flags      (wb_flags),
        .flush         (flush),
        .commit_arf    (commit_arf),
        .commit_result (commit_result),
        .commit_pc     (commit_pc),
        .commit_flags  (commit_flags),
        .commit_valid  (commit_valid)
    );

    always #5 clock = ~clock;

    // ---------------- behavioural model: live instructions in program order
    typedef struct {
        int                 idx;
        logic [ARF_W-1:0]   arf;
        logic [XLEN-1:0]    pc;
        bit                 done;
        logic [XLEN-1:0]    result;
        logic [FLAGS_W-1:0] flags;
    } m_ent_t;

    m_ent_t             m_q[$];
    int                 m_tail = 0;
    int                 m_pre_size;
    bit                 m_cv = 0;
    logic [ARF_W-1:0]   m_carf = '0;
    logic [XLEN-1:0]    m_cpc = '0;
    logic [XLEN-1:0]    m_cres = '0;
    logic [FLAGS_W-1:0] m_cflags = '0;

    always @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            m_q.delete();
            m_tail = 0; m_cv = 0;
            m_carf = '0; m_cpc = '0; m_cres = '0; m_cflags = '0;
        end else if (flush) begin
            m_q.delete();
            m_tail = 0; m_cv = 0;
        end else begin
            m_pre_size = m_q.size();
            if (m_pre_size > 0 && m_q[0].done) begin
                m_cv = 1;
                m_carf = m_q[0].arf; m_cpc = m_q[0].pc;
                m_cres = m_q[0].result; m_cflags = m_q[0].flags;
                void'(m_q.pop_front());
            end else begin
                m_cv = 0;
            end
            if (wb_valid && wb_pr < DEPTH) begin
                foreach (m_q[k]) begin
                    if (m_q[k].idx == int'(wb_pr)) begin
                        m_q[k].done = 1; m_q[k].result = wb_result; m_q[k].flags = wb_flags;
                    end
                end
            end
            if (do_alloc && m_pre_size < DEPTH) begin
                m_q.push_back('{idx: m_tail, arf: alloc_arf, pc: alloc_pc, done: 0,
                                result: '0, flags: '0});
                m_tail = (m_tail + 1) % DEPTH;
            end
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clock) begin
        check("cmp_next_free", 64'(next_free), 64'(m_tail));
        check("cmp_is_free", 64'(is_free), 64'(m_q.size() < DEPTH));
        check("cmp_commit_valid", 64'(commit_valid), 64'(m_cv));
        check("cmp_commit_arf", 64'(commit_arf), 64'(m_carf));
        check("cmp_commit_pc", commit_pc, m_cpc);
        check("cmp_commit_result", commit_result, m_cres);
        check("cmp_commit_flags", 64'(commit_flags), 64'(m_cflags));
    end

    // ---------------- driver tasks
    task automatic cycle();
        @(posedge clock);
        #1;
    endtask

    task automatic idle();
        do_alloc = 1'b0; wb_valid = 1'b0; flush = 1'b0;
    endtask

    task automatic set_alloc(input logic [ARF_W-1:0] arf, input logic [XLEN-1:0] pc);
        do_alloc = 1'b1; alloc_arf = arf; alloc_pc = pc;
    endtask

    task automatic set_wb(input int idx);
        wb_valid = 1'b1; wb_pr = PR_W'(idx);
        wb_result = {$urandom, $urandom}; wb_flags = FLAGS_W'($urandom);
    endtask

    task automatic do_flush();
        idle(); flush = 1'b1; cycle(); flush = 1'b0;
    endtask

    task automatic rand_phase(input int n, input int alloc_pct, input int wb_pct, input int flush_pm);
        for (int c = 0; c < n; c++) begin
            do_alloc  = ($urandom_range(0, 99) < alloc_pct);
            alloc_arf = ARF_W'($urandom);
            alloc_pc  = {$urandom, $urandom};
            wb_valid  = ($urandom_range(0, 99) < wb_pct);
            if (m_q.size() > 0 && $urandom_range(0, 9) < 8)
                wb_pr = PR_W'(m_q[$urandom_range(0, m_q.size() - 1)].idx);
            else
                wb_pr = PR_W'($urandom);
            wb_result = {$urandom, $urandom};
            wb_flags  = FLAGS_W'($urandom);
            flush     = ($urandom_range(0, 999) < flush_pm);
            cycle();
        end
        idle();
    endtask

    // ---------------- stimulus
    initial begin
        #1 reset_n = 1'b0;
        repeat (3) @(posedge clock);
        @(negedge clock);
        reset_n = 1'b1;
        check("rst_next_free", 64'(next_free), 64'd0);
        check("rst_is_free", 64'(is_free), 64'd1);
        check("rst_commit_valid", 64'(commit_valid), 64'd0);
        check("rst_commit_arf", 64'(commit_arf), 64'd0);

        // In-order retirement of out-of-order writebacks
        for (int i = 0; i < 3; i++) begin
            check("t1_next_free", 64'(next_free), 64'(i));
            set_alloc(ARF_W'(i + 1), 64'h100 + 64'(4 * i));
            cycle();
        end
        idle();
        check("t1_next_free3", 64'(next_free), 64'd3);
        check("t1_model_count", 64'(m_q.size()), 64'd3);
        set_wb(2); cycle();
        check("t1_cv_after_wb2", 64'(commit_valid), 64'd0);
        set_wb(0); cycle();
        check("t1_cv_after_wb0", 64'(commit_valid), 64'd0);
        set_wb(1); cycle();
        idle();
        check("t1_c0_valid", 64'(commit_valid), 64'd1);
        check("t1_c0_arf", 64'(commit_arf), 64'd1);
        check("t1_c0_pc", commit_pc, 64'h100);
        cycle();
        check("t1_c1_arf", 64'(commit_arf), 64'd2);
        check("t1_c1_pc", commit_pc, 64'h104);
        cycle();
        check("t1_c2_valid", 64'(commit_valid), 64'd1);
        check("t1_c2_arf", 64'(commit_arf), 64'd3);
        check("t1_c2_pc", commit_pc, 64'h108);
        cycle();
        check("t1_pulse_end", 64'(commit_valid), 64'd0);
        check("t1_hold_arf", 64'(commit_arf), 64'd3);

        // Fill to full, reject extra alloc, then retire entry 0
        do_flush();
        for (int i = 0; i < DEPTH; i++) begin
            set_alloc(ARF_W'($urandom), {$urandom, $urandom});
            cycle();
        end
        check("t2_full_is_free", 64'(is_free), 64'd0);
        check("t2_full_next_free", 64'(next_free), 64'd0);
        set_alloc(5'd31, 64'hdead);
        cycle();
        idle();
        check("t2_reject_next_free", 64'(next_free), 64'd0);
        check("t2_reject_count", 64'(m_q.size()), 64'(DEPTH));
        set_wb(0); cycle(); idle();
        check("t2_wb_no_commit_yet", 64'(commit_valid), 64'd0);
        cycle();
        check("t2_commit_valid", 64'(commit_valid), 64'd1);
        check("t2_is_free", 64'(is_free), 64'd1);
        check("t2_wrap_next_free", 64'(next_free), 64'd0);

        // Refill to full, then commit and alloc at the same edge; also wb->commit latency
        set_alloc(5'd9, 64'h900); cycle(); idle();
        check("t3_full_again", 64'(is_free), 64'd0);
        set_wb(1); cycle();
        idle();
        check("t4_latency_e", 64'(commit_valid), 64'd0);
        set_alloc(5'd10, 64'ha00); cycle(); idle();
        check("t4_latency_e1", 64'(commit_valid), 64'd1);
        check("t3_alloc_rejected_nf", 64'(next_free), 64'd1);
        check("t3_count", 64'(m_q.size()), 64'(DEPTH - 1));
        check("t3_is_free", 64'(is_free), 64'd1);
        set_wb(1); cycle();
        set_wb(200); cycle();
        idle(); cycle(); cycle();
        check("t4_bad_wb_no_commit", 64'(commit_valid), 64'd0);
        check("t4_bad_wb_next_free", 64'(next_free), 64'd1);

        // Random traffic: filling, mixed, draining
        do_flush();
        rand_phase(700, 80, 30, 2);
        rand_phase(700, 50, 60, 2);
        rand_phase(400, 15, 90, 0);

        // Flush with live entries, some done
        do_flush();
        for (int i = 0; i < 5; i++) begin
            set_alloc(ARF_W'(11 + i), 64'h200 + 64'(4 * i)); cycle();
        end
        idle();
        set_wb(1); cycle();
        set_wb(3); cycle();
        idle();
        check("t5_no_commit_before", 64'(commit_valid), 64'd0);
        do_flush();
        check("t5_cv", 64'(commit_valid), 64'd0);
        check("t5_next_free", 64'(next_free), 64'd0);
        check("t5_is_free", 64'(is_free), 64'd1);
        set_wb(1); cycle();
        set_wb(3); cycle();
        idle(); cycle();
        check("t5_stale_wb_cv", 64'(commit_valid), 64'd0);
        check("t5_stale_wb_nf", 64'(next_free), 64'd0);
        set_alloc(5'd17, 64'h300); cycle();
        set_alloc(5'd18, 64'h304); cycle();
        idle(); cycle(); cycle();
        check("t5_fresh_not_done", 64'(commit_valid), 64'd0);

        // Asynchronous reset in the middle of a commit stream
        do_flush();
        for (int i = 0; i < 3; i++) begin
            set_alloc(ARF_W'(7 + i), 64'h700 + 64'(4 * i)); cycle();
        end
        idle();
        set_wb(0); cycle();
        set_wb(1); cycle();
        idle();
        check("t6_pre_cv", 64'(commit_valid), 64'd1);
        check("t6_pre_arf", 64'(commit_arf), 64'd7);
        #2 reset_n = 1'b0;
        #1;
        check("t6_rst_cv", 64'(commit_valid), 64'd0);
        check("t6_rst_arf", 64'(commit_arf), 64'd0);
        check("t6_rst_pc", commit_pc, 64'd0);
        check("t6_rst_result", commit_result, 64'd0);
        check("t6_rst_flags", 64'(commit_flags), 64'd0);
        check("t6_rst_next_free", 64'(next_free), 64'd0);
        check("t6_rst_is_free", 64'(is_free), 64'd1);
        @(posedge clock); @(posedge clock);
        #3 reset_n = 1'b1;
        check("t6_post_next_free", 64'(next_free), 64'd0);
        set_alloc(5'd21, 64'hb00); cycle(); idle();
        check("t6_alloc_next_free", 64'(next_free), 64'd1);
        set_wb(0); cycle(); idle(); cycle();
        check("t6_commit_valid", 64'(commit_valid), 64'd1);
        check("t6_commit_arf", 64'(commit_arf), 64'd21);
        check("t6_commit_pc", commit_pc, 64'hb00);

        repeat (3) cycle();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
